serial_add_ctrl: RTL and testbench

Bit-serial adder controller. It sequences a single 1-bit full adder cell (`add_1bit`: inputs `A1`, `B1`, `Cin`; outputs `S1`, `Cout1`) over `WIDTH` clock cycles, producing a `WIDTH`-bit sum plus carry-out. The design is LSB-first with a registered carry between cycles and a start/busy/done handshake. It sits between a requesting master (test logic or a sequencer) and the shared full-adder datapath, which it instantiates internally.

---
 rtl/serial_add_ctrl.sv | 103 ++++++++++
 tb/tb_serial_add_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: walks one shared full-adder cell over WIDTH cycles, LSB first,
// with a registered carry between cycles and a start/busy/done handshake.

module add_1bit (
    input  logic A1,
    input  logic B1,
    input  logic Cin,
    output logic S1,
    output logic Cout1
);
    assign S1    = A1 ^ B1 ^ Cin;
    assign Cout1 = (A1 & B1) | (Cin & (A1 ^ B1));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             c_reg;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;

    add_1bit u_fa (
        .A1    (a_sr[0]),
        .B1    (b_sr[0]),
        .Cin   (c_reg),
        .S1    (s_bit),
        .Cout1 (c_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            c_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Operands track the inputs while idle; sum/cout hold the last result.
                    a_sr  <= a;
                    b_sr  <= b;
                    c_reg <= cin;
                    cnt   <= '0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    // New bit enters at the MSB so bit 0 reaches sum[0] after WIDTH shifts.
                    sum   <= (sum >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
                    c_reg <= c_bit;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout  <= c_bit;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH 8, 1 and 32 with a result scoreboard.

module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic start_1 = 1'b0, cin_1 = 1'b0, a_1 = 1'b0, b_1 = 1'b0;
    logic busy_1, done_1, cout_1, sum_1;

    logic        start32 = 1'b0, cin32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, cout32;
    logic [31:0] sum32;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0]  q8[$];
    logic [1:0]  q1[$];
    logic [32:0] q32[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_1), .a(a_1), .b(b_1), .cin(cin_1),
        .busy(busy_1), .done(done_1), .sum(sum_1), .cout(cout_1)
    );

    serial_add_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
    );

    // Start one 8-bit operation and wait (bounded) for done, measuring latency.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        output int lat, output int busy_n, output logic [8:0] got,
                        output logic single);
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        q8.push_back({1'b0, av} + {1'b0, bv} + 9'(cv));
        @(negedge clk);
        start8 = 1'b0;
        lat = 0; busy_n = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) busy_n++;
            lat++;
            @(negedge clk);
        end
        got = {cout8, sum8};
        @(negedge clk);
        single = (done8 === 1'b0);
    endtask

    task automatic test_reset();
        repeat (6) begin
            @(negedge clk);
            start8 = ~start8; start_1 = ~start_1; start32 = ~start32;
            a8 = 8'($urandom); b8 = 8'($urandom); a32 = $urandom; b32 = $urandom;
            n_tests++;
            if ({busy8, done8, cout8, sum8, busy_1, done_1, cout_1, sum_1,
                 busy32, done32, cout32, sum32} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: busy8=%b done8=%b sum8=%h cout8=%b busy1=%b done1=%b busy32=%b done32=%b sum32=%h, want all 0",
                         busy8, done8, sum8, cout8, busy_1, done_1, busy32, done32, sum32);
            end
        end
        @(negedge clk);
        start8 = 1'b0; start_1 = 1'b0; start32 = 1'b0;
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            n_tests++;
            if ({busy8, done8, cout8, sum8, busy_1, done_1, cout_1, sum_1,
                 busy32, done32, cout32, sum32} !== '0) begin
                n_fail++;
                $display("FAIL reset_release: busy8=%b done8=%b sum8=%h cout8=%b busy32=%b done32=%b, want all 0",
                         busy8, done8, sum8, cout8, busy32, done32);
            end
        end
    endtask

    task automatic test_latency();
        logic [7:0] av[2] = '{8'h00, 8'hFF};
        logic [7:0] bv[2] = '{8'h00, 8'h01};
        for (int i = 0; i < 2; i++) begin
            int lat, busy_n;
            logic [8:0] got, exp;
            logic single;
            run8(av[i], bv[i], 1'b0, lat, busy_n, got, single);
            exp = q8.pop_front();
            n_tests++;
            if (lat != 8 || busy_n != 8 || !single) begin
                n_fail++;
                $display("FAIL latency_%0d: done after %0d cycles, busy %0d cycles, single=%b; want 8, 8, 1",
                         i, lat, busy_n, single);
            end
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL latency_sum_%0d: got {cout,sum}=%h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_carry_in();
        int lat, busy_n;
        logic [8:0] got, exp;
        logic single;
        run8(8'hA5, 8'h5A, 1'b1, lat, busy_n, got, single);
        exp = q8.pop_front();
        n_tests++;
        if (got !== exp || lat != 8) begin
            n_fail++;
            $display("FAIL carry_in_a5_5a: got {cout,sum}=%h lat=%0d want %h lat=8", got, lat, exp);
        end
        run8(8'h12, 8'h34, 1'b0, lat, busy_n, got, single);
        exp = q8.pop_front();
        n_tests++;
        if (got !== exp || lat != 8) begin
            n_fail++;
            $display("FAIL carry_in_12_34: got {cout,sum}=%h lat=%0d want %h lat=8", got, lat, exp);
        end
        a8 = 8'hC3; b8 = 8'h77; cin8 = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if ({cout8, sum8} !== exp || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: got {cout,sum}=%h busy=%b want %h busy=0", {cout8, sum8}, busy8, exp);
        end
    endtask

    task automatic test_ignored_start();
        logic [8:0] exp;
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h046);
        @(negedge clk);            // cycle after accept edge k
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);            // drive for edge k+3
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk); // drive for edge k+8 and hold over the DONE edge
        start8 = 1'b1;
        @(negedge clk);
        exp = q8.pop_front();
        n_tests++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || {cout8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL ignored_start_done: done=%b busy=%b {cout,sum}=%h want done=1 busy=0 %h",
                     done8, busy8, {cout8, sum8}, exp);
        end
        @(negedge clk);
        start8 = 1'b0;
        n_tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start_done_edge: busy=%b done=%b want 0 0", busy8, done8);
        end
        @(negedge clk);
        n_tests++;
        if (busy8 !== 1'b0 || {cout8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL ignored_start_idle: busy=%b {cout,sum}=%h want busy=0 %h", busy8, {cout8, sum8}, exp);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, busy_n, saw_done;
        logic [8:0] got, exp;
        logic single;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h1FE);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        q8.delete();
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if ({busy8, done8, cout8, sum8} !== '0) begin
                n_fail++;
                $display("FAIL reset_mid_op: busy=%b done=%b sum=%h cout=%b want all 0", busy8, done8, sum8, cout8);
            end
        end
        rst = 1'b0;
        saw_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) saw_done++;
        end
        n_tests++;
        if (saw_done != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: busy/done seen in %0d cycles after release, want 0", saw_done);
        end
        run8(8'h0F, 8'h01, 1'b0, lat, busy_n, got, single);
        exp = q8.pop_front();
        n_tests++;
        if (got !== exp || lat != 8 || !single) begin
            n_fail++;
            $display("FAIL reset_restart: got {cout,sum}=%h lat=%0d single=%b want %h lat=8 single=1",
                     got, lat, single, exp);
        end
    endtask

    task automatic test_width1();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] exp;
            v = 3'(i);
            @(negedge clk);
            a_1 = v[2]; b_1 = v[1]; cin_1 = v[0]; start_1 = 1'b1;
            q1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
            @(negedge clk);
            start_1 = 1'b0;
            n_tests++;
            if (busy_1 !== 1'b1 || done_1 !== 1'b0) begin
                n_fail++;
                $display("FAIL w1_run_%0d: busy=%b done=%b want 1 0", i, busy_1, done_1);
            end
            @(negedge clk);
            exp = q1.pop_front();
            n_tests++;
            if (done_1 !== 1'b1 || {cout_1, sum_1} !== exp) begin
                n_fail++;
                $display("FAIL w1_result_%0d: done=%b {cout,sum}=%b want done=1 %b", i, done_1, {cout_1, sum_1}, exp);
            end
        end
    endtask

    task automatic test_random32();
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] av, bv;
            logic cv;
            logic [32:0] exp;
            int lat;
            av = $urandom; bv = $urandom; cv = 1'($urandom);
            @(negedge clk);
            a32 = av; b32 = bv; cin32 = cv; start32 = 1'b1;
            q32.push_back({1'b0, av} + {1'b0, bv} + 33'(cv));
            @(negedge clk);
            start32 = 1'b0;
            lat = 0;
            while (done32 !== 1'b1 && lat < 40) begin
                a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
                lat++;
                @(negedge clk);
            end
            exp = q32.pop_front();
            n_tests++;
            if (lat != 32 || {cout32, sum32} !== exp) begin
                n_fail++;
                $display("FAIL rand32_%0d: got {cout,sum}=%h lat=%0d want %h lat=32", i, {cout32, sum32}, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_carry_in();
        test_ignored_start();
        test_reset_mid_op();
        test_width1();
        test_random32();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
